// File: rtl/quad_steer_decoder.sv
// Quadrature steering decoder: synchronises and glitch-filters a two-phase pair,
// then recovers a wrapping signed position, step pulses, direction and a motion flag.
module quad_steer_decoder #(
  parameter int unsigned FILTER_LEN  = 16,
  parameter int unsigned POS_W       = 8,
  parameter int unsigned IDLE_CYCLES = 65535
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             err_clr,
  output logic [POS_W-1:0] position,
  output logic             step_cw,
  output logic             step_ccw,
  output logic             dir,
  output logic             moving,
  output logic             err_pulse,
  output logic             err_sticky
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned TMR_W = $clog2(IDLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(IDLE_CYCLES);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t state_q, state_d;

  // Channel bit 1 is phase A, bit 0 is phase B throughout.
  logic [1:0]            sync1_q;
  logic [1:0]            sync_q;
  logic [1:0]            filt_q;
  logic [1:0][CNT_W-1:0] fcnt_q;

  logic [CNT_W-1:0] init_cnt_q, init_cnt_d;
  logic [1:0]       prev_q, prev_d;
  logic [TMR_W-1:0] timer_q, timer_d;

  logic [POS_W-1:0] position_d;
  logic             step_cw_d;
  logic             step_ccw_d;
  logic             dir_d;
  logic             moving_d;
  logic             err_pulse_d;
  logic             err_sticky_d;

  // Next code in the clockwise sequence 00 -> 10 -> 11 -> 01 -> 00.
  function automatic logic [1:0] cw_next(input logic [1:0] code);
    logic [1:0] nxt;
    case (code)
      2'b00:   nxt = 2'b10;
      2'b10:   nxt = 2'b11;
      2'b11:   nxt = 2'b01;
      default: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

  // Two-flop synchroniser followed by an independent hold-time filter per channel.
  always_ff @(posedge CLK) begin
    if (reset) begin
      sync1_q <= '0;
      sync_q  <= '0;
      filt_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      sync1_q <= {quad_a, quad_b};
      sync_q  <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        if (sync_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == CNT_LAST) begin
          filt_q[i] <= sync_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Next-state and next-output logic for the decoder, idle timer and error flag.
  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    prev_d       = prev_q;
    timer_d      = timer_q;
    position_d   = position;
    step_cw_d    = 1'b0;
    step_ccw_d   = 1'b0;
    dir_d        = dir;
    moving_d     = moving;
    err_pulse_d  = 1'b0;
    err_sticky_d = err_clr ? 1'b0 : err_sticky;

    if (timer_q != '0) begin
      timer_d = timer_q - TMR_W'(1);
      if (timer_q == TMR_W'(1)) begin
        moving_d = 1'b0;
      end
    end

    case (state_q)
      S_INIT: begin
        // Wait until both filters have settled so a non-zero start level is not a step.
        if (sync_q == filt_q) begin
          if (init_cnt_q == CNT_LAST) begin
            state_d    = S_RUN;
            prev_d     = filt_q;
            init_cnt_d = '0;
          end else begin
            init_cnt_d = init_cnt_q + CNT_W'(1);
          end
        end else begin
          init_cnt_d = '0;
        end
      end
      S_RUN: begin
        prev_d = filt_q;
        if (filt_q != prev_q) begin
          if (filt_q == cw_next(prev_q)) begin
            position_d = position + POS_W'(1);
            step_cw_d  = 1'b1;
            dir_d      = 1'b1;
            timer_d    = TMR_LOAD;
            moving_d   = 1'b1;
          end else if (prev_q == cw_next(filt_q)) begin
            position_d = position - POS_W'(1);
            step_ccw_d = 1'b1;
            dir_d      = 1'b0;
            timer_d    = TMR_LOAD;
            moving_d   = 1'b1;
          end else begin
            err_pulse_d  = 1'b1;
            err_sticky_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      prev_q     <= '0;
      timer_q    <= '0;
      position   <= '0;
      step_cw    <= 1'b0;
      step_ccw   <= 1'b0;
      dir        <= 1'b0;
      moving     <= 1'b0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      prev_q     <= prev_d;
      timer_q    <= timer_d;
      position   <= position_d;
      step_cw    <= step_cw_d;
      step_ccw   <= step_ccw_d;
      dir        <= dir_d;
      moving     <= moving_d;
      err_pulse  <= err_pulse_d;
      err_sticky <= err_sticky_d;
    end
  end

endmodule
